gol_generation_sequencer: RTL

Hardware initiator for the Game of Life engine's start/completed control handshake, replacing per-generation software sequencing from the HPS. Given two board buffers in on-chip memory and a generation count, it repeatedly initializes and starts the engine, waits for completion, swaps source/result buffers, and reports where the final board lives. It sits between the HPS control PIOs and the engine's `io_initialize`/`io_start`/`io_completed`/address/dimension inputs.

---
 rtl/gol_pkg.sv | 23 ++
 rtl/gol_watchdog.sv | 49 ++++
 rtl/gol_generation_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life generation sequencer: default
// widths, the default per-generation watchdog limit and the sequencer states.
package gol_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DIM_W_DEF  = 8;
    localparam int GEN_W_DEF  = 16;

    // Width of the per-generation watchdog counter and its default limit.
    localparam int              TIMEOUT_W          = 24;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES_DEF = 24'd10_000_000;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

endpackage : gol_pkg

// File: rtl/gol_watchdog.sv
// Per-generation watchdog: a loadable down-counter.
// The budget includes the INIT cycle, so with a limit of T the sequencer
// leaves for ERROR T cycles after INIT when the engine never finishes.
// load_i (asserted during INIT) preloads LIMIT-1; every count_i cycle
// decrements. expired_o flags the last allowed cycle so the state machine
// can register the ERROR transition on that same edge. LIMIT is expected
// to be at least 2.
module gol_watchdog
    import gol_pkg::*;
#(
    parameter int             CNT_W = TIMEOUT_W,
    parameter logic [CNT_W-1:0] LIMIT = TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: preload on load, saturating decrement while counting.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LIMIT - ONE;
        end else if (count_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Last allowed cycle of the generation: the transition taken on this
    // edge lands in the cycle where the budget is exhausted.
    assign expired_o = count_i && (count_q <= ONE);

endmodule : gol_watchdog

// File: rtl/gol_generation_sequencer.sv
// Generation sequencer for the Game of Life engine. Runs the engine for a
// requested number of generations, ping-ponging between two board buffers,
// and reports which buffer holds the latest completed board.
module gol_generation_sequencer
    import gol_pkg::*;
#(
    parameter int                    ADDR_W         = ADDR_W_DEF,
    parameter int                    DIM_W          = DIM_W_DEF,
    parameter int                    GEN_W          = GEN_W_DEF,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              abort,
    input  logic [GEN_W-1:0]  num_generations,
    input  logic [ADDR_W-1:0] buf_a_addr,
    input  logic [ADDR_W-1:0] buf_b_addr,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  columns,
    input  logic              engine_completed,
    output logic              engine_initialize,
    output logic              engine_start,
    output logic [ADDR_W-1:0] engine_start_address,
    output logic [ADDR_W-1:0] engine_result_address,
    output logic [DIM_W-1:0]  engine_rows,
    output logic [DIM_W-1:0]  engine_columns,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [GEN_W-1:0]  gen_count,
    output logic [ADDR_W-1:0] final_address
);

    state_e            state_q,     state_d;
    logic [GEN_W-1:0]  num_gen_q,   num_gen_d;
    logic [ADDR_W-1:0] src_q,       src_d;
    logic [ADDR_W-1:0] dst_q,       dst_d;
    logic [DIM_W-1:0]  rows_q,      rows_d;
    logic [DIM_W-1:0]  cols_q,      cols_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic [ADDR_W-1:0] final_q,     final_d;
    logic              done_q,      done_d;
    logic              error_q,     error_d;

    logic              wd_load;
    logic              wd_count;
    logic              wd_expired;
    logic [GEN_W-1:0]  gen_next;

    assign gen_next = gen_count_q + GEN_W'(1);
    assign wd_load  = (state_q == ST_INIT);
    assign wd_count = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    gol_watchdog #(
        .CNT_W (TIMEOUT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .load_i    (wd_load),
        .count_i   (wd_count),
        .expired_o (wd_expired)
    );

    // Next-state and datapath updates; priority is abort, timeout, normal.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        num_gen_d   = num_gen_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        gen_count_d = gen_count_q;
        final_d     = final_q;
        done_d      = done_q;
        error_d     = error_q;

        if (abort && (state_q != ST_IDLE)) begin
            // Counters and final_address keep the last completed values.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // A still-high completion flag from a previous job
                    // holds off a new run until the engine is quiet.
                    if (run && !engine_completed && !abort) begin
                        num_gen_d   = num_generations;
                        src_d       = buf_a_addr;
                        dst_d       = buf_b_addr;
                        rows_d      = rows;
                        cols_d      = columns;
                        gen_count_d = '0;
                        done_d      = 1'b0;
                        error_d     = 1'b0;
                        if (num_generations == '0) begin
                            final_d = buf_a_addr;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_INIT;
                        end
                    end
                end

                ST_INIT: begin
                    state_d = ST_RUN;
                end

                ST_RUN: begin
                    if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end else if (engine_completed) begin
                        state_d = ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = ST_ERROR;
                    end else if (!engine_completed) begin
                        // The result buffer becomes the next source.
                        gen_count_d = gen_next;
                        src_d       = dst_q;
                        dst_d       = src_q;
                        final_d     = dst_q;
                        if (gen_next == num_gen_q) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_INIT;
                        end
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                ST_ERROR: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            num_gen_q   <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            gen_count_q <= '0;
            final_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            num_gen_q   <= num_gen_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            gen_count_q <= gen_count_d;
            final_q     <= final_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign engine_initialize     = (state_q == ST_INIT);
    assign engine_start          = (state_q == ST_RUN);
    assign busy                  = (state_q == ST_INIT) || (state_q == ST_RUN) ||
                                   (state_q == ST_DRAIN);
    assign engine_start_address  = src_q;
    assign engine_result_address = dst_q;
    assign engine_rows           = rows_q;
    assign engine_columns        = cols_q;
    assign gen_count             = gen_count_q;
    assign final_address         = final_q;
    assign done                  = done_q;
    assign error                 = error_q;

endmodule : gol_generation_sequencer
